// File: rtl/pair_bit_sequencer.sv
// Purpose : drains a request vector two set bits per beat, lowest index first.
// Latency : first beat valid the cycle after the vector is accepted, then one beat per accepted cycle.
// Backpres: beat outputs and pending bits hold while pair_ready_i is low; no new vector until drained.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   vec_valid_i/vec_i         request vector in, accepted when vec_ready_o (block idle)
//   abort_i                   drops the remaining pending bits while emitting
//   pair_valid_o/pair_ready_i beat handshake
//   first_o/second_o          one-hot lowest / second-lowest pending bit (second 0 if none)
//   first_idx_o/second_idx_o  binary indices of the above
//   second_vld_o, last_o      second bit present / this beat empties pending
//   pair_cnt_o                completed beats since reset, wraps at 256
module pair_bit_sequencer #(
    parameter int WIDTH = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     vec_valid_i,
    input  logic [WIDTH-1:0]         vec_i,
    output logic                     vec_ready_o,
    input  logic                     abort_i,
    output logic                     pair_valid_o,
    input  logic                     pair_ready_i,
    output logic [WIDTH-1:0]         first_o,
    output logic [WIDTH-1:0]         second_o,
    output logic [$clog2(WIDTH)-1:0] first_idx_o,
    output logic [$clog2(WIDTH)-1:0] second_idx_o,
    output logic                     second_vld_o,
    output logic                     last_o,
    output logic [7:0]               pair_cnt_o
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pending, pending_nxt;
    logic [7:0]       pair_cnt;
    logic             cnt_inc;

    logic [WIDTH-1:0] first_bit, rest_bits, second_bit, remain_bits;
    logic [IW-1:0]    first_idx, second_idx;
    logic             in_emit;

    // Index of a one-hot (or zero) vector; zero input maps to index 0.
    function automatic logic [IW-1:0] oh2idx(input logic [WIDTH-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (oh[i]) begin
                r = IW'(i);
            end
        end
        return r;
    endfunction

    // Two's-complement trick isolates the lowest set bit; applying it twice
    // on what is left yields the second-lowest.
    always_comb begin
        first_bit   = pending & (~pending + ONE);
        rest_bits   = pending & ~first_bit;
        second_bit  = rest_bits & (~rest_bits + ONE);
        remain_bits = rest_bits & ~second_bit;
        first_idx   = oh2idx(first_bit);
        second_idx  = oh2idx(second_bit);
    end

    assign in_emit      = (state == EMIT);
    assign vec_ready_o  = (state == IDLE);
    assign pair_valid_o = in_emit;

    // Beat fields are forced to zero outside EMIT so idle outputs are clean.
    assign first_o      = in_emit ? first_bit  : '0;
    assign second_o     = in_emit ? second_bit : '0;
    assign first_idx_o  = in_emit ? first_idx  : '0;
    assign second_idx_o = in_emit ? second_idx : '0;
    assign second_vld_o = in_emit & (second_bit != '0);
    assign last_o       = in_emit & (remain_bits == '0);
    assign pair_cnt_o   = pair_cnt;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        cnt_inc     = 1'b0;
        case (state)
            IDLE: begin
                // abort_i has no meaning while idle; an all-zero vector is
                // consumed without producing a beat.
                if (vec_valid_i && (vec_i != '0)) begin
                    pending_nxt = vec_i;
                    state_nxt   = EMIT;
                end
            end
            EMIT: begin
                // Abort takes priority over a same-cycle handshake.
                if (abort_i) begin
                    pending_nxt = '0;
                    state_nxt   = IDLE;
                end else if (pair_ready_i) begin
                    pending_nxt = remain_bits;
                    cnt_inc     = 1'b1;
                    if (remain_bits == '0) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                pending_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            pending  <= '0;
            pair_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (cnt_inc) begin
                pair_cnt <= pair_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pair_bit_sequencer.sv
// Purpose : scoreboard bench for pair_bit_sequencer with directed and random vectors.
// Latency : expected beats queued at vector issue, checked by a negedge monitor.
// Backpres: ready pattern selectable (always, toggling, random with random aborts).
module tb_pair_bit_sequencer;

    localparam int WIDTH = 12;
    localparam int IW    = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             vec_valid_i = 1'b0;
    logic [WIDTH-1:0] vec_i = '0;
    logic             vec_ready_o;
    logic             abort_i = 1'b0;
    logic             pair_valid_o;
    logic             pair_ready_i = 1'b1;
    logic [WIDTH-1:0] first_o, second_o;
    logic [IW-1:0]    first_idx_o, second_idx_o;
    logic             second_vld_o, last_o;
    logic [7:0]       pair_cnt_o;

    pair_bit_sequencer #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .vec_valid_i  (vec_valid_i),
        .vec_i        (vec_i),
        .vec_ready_o  (vec_ready_o),
        .abort_i      (abort_i),
        .pair_valid_o (pair_valid_o),
        .pair_ready_i (pair_ready_i),
        .first_o      (first_o),
        .second_o     (second_o),
        .first_idx_o  (first_idx_o),
        .second_idx_o (second_idx_o),
        .second_vld_o (second_vld_o),
        .last_o       (last_o),
        .pair_cnt_o   (pair_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [WIDTH-1:0] first;
        logic [WIDTH-1:0] second;
        logic [IW-1:0]    fi;
        logic [IW-1:0]    si;
        logic             sv;
        logic             last;
        int               vid;
    } beat_t;

    beat_t      exp_q[$];
    int         n_total = 0;
    int         n_pass  = 0;
    logic [7:0] cnt_model = 8'd0;
    logic       expect_idle = 1'b0;
    int         vid_ctr = 0;
    int         ready_mode = 0;  // 0: always ready, 1: toggle, 2: random + random abort

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: list set bits in ascending order and group them in pairs.
    task automatic push_beats(input logic [WIDTH-1:0] v, input int vid);
        int    idx[$];
        beat_t b;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx.push_back(i);
        end
        for (int k = 0; k < idx.size(); k += 2) begin
            b.first = 12'd1 << idx[k];
            b.fi    = IW'(idx[k]);
            if (k + 1 < idx.size()) begin
                b.second = 12'd1 << idx[k+1];
                b.si     = IW'(idx[k+1]);
                b.sv     = 1'b1;
            end else begin
                b.second = '0;
                b.si     = '0;
                b.sv     = 1'b0;
            end
            b.last = (k + 2 >= idx.size());
            b.vid  = vid;
            exp_q.push_back(b);
        end
    endtask

    // Ready / random-abort driver, changes inputs just after the rising edge.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            case (ready_mode)
                0: pair_ready_i = 1'b1;
                1: pair_ready_i = ~pair_ready_i;
                default: begin
                    pair_ready_i = ($urandom_range(0, 2) != 0);
                    abort_i      = ($urandom_range(0, 15) == 0);
                end
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                exp_q.delete();
                cnt_model   = 8'd0;
                expect_idle = 1'b0;
            end else begin
                chk("pair_cnt", {24'd0, pair_cnt_o}, {24'd0, cnt_model});
                if (expect_idle) begin
                    chk("idle_vec_ready", {31'd0, vec_ready_o}, 32'd1);
                    chk("idle_pair_valid", {31'd0, pair_valid_o}, 32'd0);
                    expect_idle = 1'b0;
                end
                if (pair_valid_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", {31'd0, pair_valid_o}, 32'd0);
                    end else begin
                        chk("first_o", {20'd0, first_o}, {20'd0, exp_q[0].first});
                        chk("second_o", {20'd0, second_o}, {20'd0, exp_q[0].second});
                        chk("first_idx", {28'd0, first_idx_o}, {28'd0, exp_q[0].fi});
                        chk("second_idx", {28'd0, second_idx_o}, {28'd0, exp_q[0].si});
                        chk("second_vld", {31'd0, second_vld_o}, {31'd0, exp_q[0].sv});
                        chk("last_o", {31'd0, last_o}, {31'd0, exp_q[0].last});
                        if (abort_i) begin
                            int v0;
                            v0 = exp_q[0].vid;
                            while (exp_q.size() > 0 && exp_q[0].vid == v0) void'(exp_q.pop_front());
                            expect_idle = 1'b1;
                        end else if (pair_ready_i) begin
                            expect_idle = exp_q[0].last;
                            void'(exp_q.pop_front());
                            cnt_model = cnt_model + 8'd1;
                        end
                    end
                end else begin
                    chk("idle_beat_zero",
                        {first_o, second_o, first_idx_o, second_idx_o, second_vld_o, last_o},
                        32'd0);
                end
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] v, input logic with_abort);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (vec_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("issue_timeout", 32'd0, 32'd1);
        end else begin
            vid_ctr++;
            push_beats(v, vid_ctr);
            vec_valid_i = 1'b1;
            vec_i       = v;
            if (with_abort) abort_i = 1'b1;
            @(posedge clk_i);
            #1;
            vec_valid_i = 1'b0;
            if (with_abort) abort_i = 1'b0;
            @(negedge clk_i);
            chk("accept_valid", {31'd0, pair_valid_o}, {31'd0, (v != '0)});
            chk("accept_ready", {31'd0, vec_ready_o}, {31'd0, (v == '0)});
        end
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (vec_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        chk("watchdog", 32'd0, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        logic [7:0] cnt_before;
        #12;
        chk("rst_vec_ready", {31'd0, vec_ready_o}, 32'd1);
        chk("rst_pair_valid", {31'd0, pair_valid_o}, 32'd0);
        chk("rst_cnt", {24'd0, pair_cnt_o}, 32'd0);
        chk("rst_first", {20'd0, first_o}, 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Directed patterns.
        ready_mode = 0;
        issue(12'h0A6, 1'b0);
        wait_idle();
        chk("cnt_after_0A6", {24'd0, pair_cnt_o}, 32'd2);
        issue(12'h100, 1'b0);
        wait_idle();
        ready_mode = 1;
        issue(12'hFFF, 1'b0);
        wait_idle();
        ready_mode = 0;
        issue(12'h000, 1'b0);
        issue(12'h800, 1'b0);
        wait_idle();

        // Abort during the second beat of an all-ones vector.
        cnt_before = cnt_model;
        issue(12'hFFF, 1'b0);
        @(posedge clk_i);
        #1 abort_i = 1'b1;
        @(posedge clk_i);
        #1 abort_i = 1'b0;
        @(negedge clk_i);
        chk("abort_idle", {31'd0, vec_ready_o}, 32'd1);
        chk("abort_cnt", {24'd0, pair_cnt_o}, {24'd0, 8'(cnt_before + 8'd1)});

        // Abort while idle must not block vector acceptance.
        issue(12'h421, 1'b1);
        wait_idle();

        // Asynchronous reset in the middle of a drain.
        ready_mode = 1;
        issue(12'hFFF, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("mid_rst_vec_ready", {31'd0, vec_ready_o}, 32'd1);
        chk("mid_rst_pair_valid", {31'd0, pair_valid_o}, 32'd0);
        chk("mid_rst_cnt", {24'd0, pair_cnt_o}, 32'd0);
        chk("mid_rst_first", {20'd0, first_o}, 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        ready_mode = 0;

        // Random vectors with random backpressure and aborts.
        ready_mode = 2;
        for (int n = 0; n < 80; n++) begin
            logic [WIDTH-1:0] rv;
            rv = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
            issue(rv, 1'b0);
        end
        wait_idle();
        ready_mode = 0;
        @(posedge clk_i);
        #2 abort_i = 1'b0;
        wait_idle();

        // Counter wrap: 256 single-bit vectors from a fresh reset.
        do_reset();
        for (int n = 0; n < 255; n++) begin
            issue(12'd1 << $urandom_range(0, WIDTH - 1), 1'b0);
        end
        wait_idle();
        chk("cnt_255", {24'd0, pair_cnt_o}, 32'd255);
        issue(12'd1 << $urandom_range(0, WIDTH - 1), 1'b0);
        wait_idle();
        chk("cnt_wrap", {24'd0, pair_cnt_o}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
